snow64_main_mem_arbiter: RTL
============================

Name: snow64_main_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port main memory (1-cycle registered read, write on clk edge).
- Port 0 serves instruction fetch; port 1 serves the LAR-file data path.
- Grants one access at a time, drives the memory address/write/data lines, captures the read data and returns it with a one-cycle ack pulse.
- Fairness is round-robin when both requesters are valid.

Parameters:
WIDTH__ADDR, 27, word address width; matches main-memory address port
WIDTH__DATA, 256, data word width; matches main-memory data port

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_req0_valid  in  1  port 0 request; held high until out_req0_ack
in_req0_wr  in  1  port 0: 1=write, 0=read
in_req0_addr  in  WIDTH__ADDR  port 0 word address
in_req0_data  in  WIDTH__DATA  port 0 write data
out_req0_ack  out  1  port 0 completion pulse
out_req0_data  out  WIDTH__DATA  port 0 read data; valid while ack is high
in_req1_valid, in_req1_wr, in_req1_addr, in_req1_data  in  1/1/WIDTH__ADDR/WIDTH__DATA  port 1, same meaning as port 0
out_req1_ack, out_req1_data  out  1/WIDTH__DATA  port 1, same meaning as port 0
out_mem_req_wr  out  1  memory write enable
out_mem_addr  out  WIDTH__ADDR  memory address
out_mem_data  out  WIDTH__DATA  memory write data
in_mem_data  in  WIDTH__DATA  memory registered read data
out_busy  out  1  high in any state other than IDLE

Behaviour:
- State machine: IDLE -> ACCESS -> FINISH -> IDLE. There is no other path.
- IDLE, arbitration:
  - A port is eligible when its valid is high and its ack is not asserted this cycle. This masking prevents a duplicate grant while the requester is still dropping valid.
  - If exactly one port is eligible, it is granted.
  - If both are eligible, the port not granted last is granted (last_grant bit), and last_grant is updated.
  - On a grant, wr, addr, data and the port id are latched; next state is ACCESS.
  - If no port is eligible, stay in IDLE.
- ACCESS:
  - out_mem_addr and out_mem_data come from the latched values. They are registered at the grant edge and hold their last value otherwise.
  - out_mem_req_wr = (state==ACCESS) && latched_wr && !rst, driven combinationally.
  - The memory performs the access at the end-of-cycle edge. Next state is FINISH.
- FINISH:
  - in_mem_data holds the read result.
  - At the end-of-cycle edge, on a read, out_reqN_data <= in_mem_data for the granted port only. On a write, out_reqN_data is unchanged.
  - out_reqN_ack <= 1 for the granted port. Next state is IDLE.
- Latency: valid sampled in cycle T (IDLE) -> memory access edge at end of T+1 -> ack high during T+3 for exactly 1 cycle. Throughput is one access per 3 cycles.
- Acks are registered, mutually exclusive, and deassert the cycle after assertion.
- The requester must keep valid, wr, addr and data stable from assertion until its ack cycle. It may reassert valid in the cycle after ack.
- Only the latched copy is used after the grant. Input changes after the grant do not affect the access in flight.
- Reset values: state=IDLE, last_grant=1 (port 0 wins the first tie), both acks 0, both out data 0, out_mem_addr 0, out_mem_data 0, out_busy 0.
- Reset mid-operation:
  - The sync reset aborts the access and produces no ack.
  - rst high during ACCESS suppresses out_mem_req_wr in that cycle, so no memory write occurs.
  - rst during FINISH blocks the ack and the data update.
- Simultaneous events: new requests arriving during ACCESS or FINISH wait for IDLE. A port whose ack is high is ineligible that cycle, so the other valid port is granted immediately.
- Address passes through unchanged. Addresses beyond memory size wrap per the memory itself; the arbiter performs no range checking.

Test Plan:
- Reset, then port 0 read addr 0x10 (mem[0x10] preloaded 0xAB..AB) at T=2 -> out_mem_addr=0x10 in T=3, out_req0_ack=1 at T=5 only, out_req0_data=0xAB..AB; port 1 outputs stay 0.
- Port 1 write addr 0x1000 data 0x1234, then port 1 read addr 0x1000 -> out_mem_req_wr high exactly one cycle; read returns 0x1234; out_req1_data unchanged across the write ack.
- Both ports valid continuously with reads of 0x1 and 0x2 -> grant order 0,1,0,1; ack spacing 3 cycles; never both acks high; no duplicate grant in an ack cycle.
- Port 0 valid alone held across its ack, dropped the cycle after -> exactly one access; port 1 request arriving during ACCESS is served next with ack 3 cycles after IDLE entry.
- Port 1 write 0xFFFF to 0x20 with rst pulsed during ACCESS -> out_mem_req_wr stays 0, mem[0x20] keeps its old value, no ack; all outputs at reset values; the next request works normally.
- Port 0 changes addr from 0x5 to 0x6 in the cycle after grant -> the access still uses 0x5.

Source files
------------

// File: rtl/snow64_main_mem_arbiter_if.sv
// snow64_main_mem_arbiter_if
// Bundles both requester handshakes and the single-port main-memory lines.
// The arbiter takes the slave view. The requesters and the memory together
// take the master view.
interface snow64_main_mem_arbiter_if #(
    parameter int WIDTH__ADDR = 27,
    parameter int WIDTH__DATA = 256
);

    // Port 0: instruction fetch
    logic                   in_req0_valid;
    logic                   in_req0_wr;
    logic [WIDTH__ADDR-1:0] in_req0_addr;
    logic [WIDTH__DATA-1:0] in_req0_data;
    logic                   out_req0_ack;
    logic [WIDTH__DATA-1:0] out_req0_data;

    // Port 1: LAR-file data path
    logic                   in_req1_valid;
    logic                   in_req1_wr;
    logic [WIDTH__ADDR-1:0] in_req1_addr;
    logic [WIDTH__DATA-1:0] in_req1_data;
    logic                   out_req1_ack;
    logic [WIDTH__DATA-1:0] out_req1_data;

    // Main memory: 1-cycle registered read, write on the clock edge
    logic                   out_mem_req_wr;
    logic [WIDTH__ADDR-1:0] out_mem_addr;
    logic [WIDTH__DATA-1:0] out_mem_data;
    logic [WIDTH__DATA-1:0] in_mem_data;

    // Status
    logic                   out_busy;

    modport slave (
        input  in_req0_valid,
        input  in_req0_wr,
        input  in_req0_addr,
        input  in_req0_data,
        output out_req0_ack,
        output out_req0_data,
        input  in_req1_valid,
        input  in_req1_wr,
        input  in_req1_addr,
        input  in_req1_data,
        output out_req1_ack,
        output out_req1_data,
        output out_mem_req_wr,
        output out_mem_addr,
        output out_mem_data,
        input  in_mem_data,
        output out_busy
    );

    modport master (
        output in_req0_valid,
        output in_req0_wr,
        output in_req0_addr,
        output in_req0_data,
        input  out_req0_ack,
        input  out_req0_data,
        output in_req1_valid,
        output in_req1_wr,
        output in_req1_addr,
        output in_req1_data,
        input  out_req1_ack,
        input  out_req1_data,
        input  out_mem_req_wr,
        input  out_mem_addr,
        input  out_mem_data,
        output in_mem_data,
        input  out_busy
    );

endinterface

// File: rtl/snow64_main_mem_arbiter.sv
// snow64_main_mem_arbiter
// Two-requester arbiter and sequencer for the single-port main memory.
// Every access walks IDLE -> ACCESS -> FINISH -> IDLE.
// The memory samples the latched address/data at the end of ACCESS.
// Its registered read data is captured at the end of FINISH, together with a
// one-cycle ack to the granted port. Ties are broken round-robin.
module snow64_main_mem_arbiter #(
    parameter int WIDTH__ADDR = 27,
    parameter int WIDTH__DATA = 256
) (
    input logic                     clk,
    input logic                     rst,
    snow64_main_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_last_grant;
    logic                   r_port;
    logic                   r_wr;
    logic [WIDTH__ADDR-1:0] r_mem_addr;
    logic [WIDTH__DATA-1:0] r_mem_data;
    logic                   r_ack0;
    logic                   r_ack1;
    logic [WIDTH__DATA-1:0] r_data0;
    logic [WIDTH__DATA-1:0] r_data1;

    logic                   w_elig0;
    logic                   w_elig1;
    logic                   w_grant;
    logic                   w_grant_port;
    logic                   w_grant_wr;
    logic [WIDTH__ADDR-1:0] w_grant_addr;
    logic [WIDTH__DATA-1:0] w_grant_data;

    // Eligibility masks out a port whose ack is high this cycle, because that requester
    // may still be holding valid. On a tie, the port not granted last wins.
    always_comb begin
        w_elig0 = bus.in_req0_valid && !r_ack0;
        w_elig1 = bus.in_req1_valid && !r_ack1;
        w_grant = w_elig0 || w_elig1;
        if (w_elig0 && w_elig1) begin
            w_grant_port = ~r_last_grant;
        end else begin
            w_grant_port = w_elig1;
        end
        if (w_grant_port) begin
            w_grant_wr   = bus.in_req1_wr;
            w_grant_addr = bus.in_req1_addr;
            w_grant_data = bus.in_req1_data;
        end else begin
            w_grant_wr   = bus.in_req0_wr;
            w_grant_addr = bus.in_req0_addr;
            w_grant_data = bus.in_req0_data;
        end
    end

    // Sequencer: latch the winner in IDLE, let the memory act in ACCESS,
    // and deliver the ack/read data in FINISH. A sync reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_wr         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= ST_ACCESS;
                        r_port       <= w_grant_port;
                        r_last_grant <= w_grant_port;
                        r_wr         <= w_grant_wr;
                        r_mem_addr   <= w_grant_addr;
                        r_mem_data   <= w_grant_data;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_FINISH;
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    if (r_port) begin
                        r_ack1 <= 1'b1;
                        if (!r_wr) begin
                            r_data1 <= bus.in_mem_data;
                        end
                    end else begin
                        r_ack0 <= 1'b1;
                        if (!r_wr) begin
                            r_data0 <= bus.in_mem_data;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The write strobe is gated by rst, so a reset during ACCESS never reaches the memory.
    assign bus.out_mem_req_wr = (r_state == ST_ACCESS) && r_wr && !rst;
    assign bus.out_mem_addr   = r_mem_addr;
    assign bus.out_mem_data   = r_mem_data;
    assign bus.out_req0_ack   = r_ack0;
    assign bus.out_req1_ack   = r_ack1;
    assign bus.out_req0_data  = r_data0;
    assign bus.out_req1_data  = r_data1;
    assign bus.out_busy       = (r_state != ST_IDLE);

endmodule
